// File: rtl/multi_initiator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multi_initiator_pkg
// Description : Shared types and constants for the start/done initiator.
//               Holds the FSM state encoding and the default watchdog limit.
// Revision    : 1.0  initial release
// ============================================================================
package multi_initiator_pkg;

  // Default number of WAIT cycles before a transaction is aborted.
  localparam int TIMEOUT_DEFAULT = 15;

  // Width of the saturating wait counter.
  localparam int WD_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/multi_initiator_if.sv
`default_nettype none
// ============================================================================
// Module      : multi_initiator_if
// Description : Bundle of the request stream, the start/done responder link,
//               the response stream and the sticky error flag.
//               master : initiator view (drives req_ready, mc_*, rsp_*)
//               slave  : environment view (upstream, responder, downstream)
// Revision    : 1.0  initial release
// ============================================================================
interface multi_initiator_if #(
  parameter int WIDTH = 32
);
  // Upstream request stream
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  // Multi-cycle responder link
  logic             mc_start;
  logic [WIDTH-1:0] mc_inp;
  logic             mc_done;
  logic [WIDTH-1:0] mc_out;
  // Downstream response stream
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_timeout;
  // Status
  logic             err_spurious;

  modport master (
    input  req_valid, req_data, mc_done, mc_out, rsp_ready,
    output req_ready, mc_start, mc_inp, rsp_valid, rsp_data, rsp_timeout,
           err_spurious
  );

  modport slave (
    output req_valid, req_data, mc_done, mc_out, rsp_ready,
    input  req_ready, mc_start, mc_inp, rsp_valid, rsp_data, rsp_timeout,
           err_spurious
  );

endinterface
`default_nettype wire

// File: rtl/multi_initiator_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : multi_watchdog
// Description : Saturating 8-bit wait counter. 'clear' zeroes it, 'enable'
//               advances it (never wrapping), 'expired' flags that the
//               counter sits at TIMEOUT-1, i.e. the last allowed WAIT cycle.
// Ports       : clock, reset_n (async, active-low), clear, enable, expired
// Revision    : 1.0  initial release
// ============================================================================
module multi_watchdog
  import multi_initiator_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  wire logic clock,
  input  wire logic reset_n,
  input  wire logic clear,
  input  wire logic enable,
  output logic      expired
);

  localparam logic [WD_WIDTH-1:0] LIMIT   = WD_WIDTH'(TIMEOUT - 1);
  localparam logic [WD_WIDTH-1:0] SAT_MAX = '1;

  logic [WD_WIDTH-1:0] r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != SAT_MAX)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign expired = (r_count == LIMIT);

endmodule
`default_nettype wire

// File: rtl/multi_initiator.sv
`default_nettype none
// ============================================================================
// Module      : multi_initiator
// Description : Initiator side of a start/done multi-cycle handshake. Accepts
//               one request, pulses mc_start with the operand held on mc_inp,
//               waits for mc_done (bounded by a watchdog), then presents the
//               result (or a zero timeout response) on the response stream.
// Ports       : clock        - sole clock, rising edge
//               reset_n      - asynchronous active-low reset
//               bus (master) - request, responder, response and error signals
// Revision    : 1.0  initial release
// ============================================================================
module multi_initiator
  import multi_initiator_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input wire logic          clock,
  input wire logic          reset_n,
  multi_initiator_if.master bus
);

  state_t           state;
  logic [WIDTH-1:0] r_operand;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_valid;
  logic             r_rsp_timeout;
  logic             r_mc_start;
  logic             r_err_spurious;
  logic             w_expired;

  multi_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state == ISSUE),
    .enable  (state == WAIT),
    .expired (w_expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      r_operand      <= '0;
      r_rsp_data     <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_timeout  <= 1'b0;
      r_mc_start     <= 1'b0;
      r_err_spurious <= 1'b0;
    end else begin
      r_mc_start <= 1'b0;

      // A done outside the wait window (including a late one after an
      // abort) is only recorded, never acted upon.
      if (bus.mc_done && (state != WAIT)) begin
        r_err_spurious <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            r_operand  <= bus.req_data;
            r_mc_start <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          // done takes priority over expiry on the same cycle
          if (bus.mc_done) begin
            r_rsp_data    <= bus.mc_out;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            state         <= RESP;
          end else if (w_expired) begin
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready    = (state == IDLE);
  assign bus.mc_start     = r_mc_start;
  assign bus.mc_inp       = r_operand;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_data     = r_rsp_data;
  assign bus.rsp_timeout  = r_rsp_timeout;
  assign bus.err_spurious = r_err_spurious;

endmodule
`default_nettype wire

// File: tb/tb_multi_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_initiator
// Description : Directed self-checking bench for multi_initiator (TIMEOUT=4).
//               Inputs change 1 time unit after a rising edge; outputs are
//               checked at the same point, away from the active edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_multi_initiator;
  import multi_initiator_pkg::*;

  localparam int WIDTH      = 32;
  localparam int TB_TIMEOUT = 4;

  logic clock;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  multi_initiator_if #(.WIDTH(WIDTH)) bus ();

  multi_initiator #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus.req_valid = 1'b0;
    bus.req_data  = '0;
    bus.mc_done   = 1'b0;
    bus.mc_out    = '0;
    bus.rsp_ready = 1'b0;
    reset_n       = 1'b1;

    // ---------------- reset ----------------
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mc_start",  32'(bus.mc_start), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data",  bus.rsp_data, 32'd0);
    chk("rst_mc_inp",    bus.mc_inp, 32'd0);
    chk("rst_err",       32'(bus.err_spurious), 32'd0);
    step(); step();
    reset_n = 1'b1;
    step();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);

    // ---------------- basic: done at t+3 ----------------
    bus.req_valid = 1'b1;
    bus.req_data  = 32'hDEADBEEF;
    chk("basic_ready_t", 32'(bus.req_ready), 32'd1);
    chk("basic_start_t", 32'(bus.mc_start), 32'd0);
    step();                                     // t+1
    bus.req_valid = 1'b0;
    bus.req_data  = 32'h0;
    chk("basic_start_t1", 32'(bus.mc_start), 32'd1);
    chk("basic_inp_t1",   bus.mc_inp, 32'hDEADBEEF);
    chk("basic_ready_t1", 32'(bus.req_ready), 32'd0);
    step();                                     // t+2
    chk("basic_start_t2", 32'(bus.mc_start), 32'd0);
    chk("basic_state_t2", 32'(dut.state), 32'(WAIT));
    step();                                     // t+3
    bus.mc_done = 1'b1;
    bus.mc_out  = 32'hDEADBEEF;
    chk("basic_valid_t3", 32'(bus.rsp_valid), 32'd0);
    step();                                     // t+4
    bus.mc_done = 1'b0;
    bus.mc_out  = 32'h0;
    chk("basic_valid_t4", 32'(bus.rsp_valid), 32'd1);
    chk("basic_data_t4",  bus.rsp_data, 32'hDEADBEEF);
    chk("basic_tmo_t4",   32'(bus.rsp_timeout), 32'd0);
    chk("basic_inp_t4",   bus.mc_inp, 32'hDEADBEEF);
    bus.rsp_ready = 1'b1;
    step();                                     // t+5
    bus.rsp_ready = 1'b0;
    chk("basic_valid_t5", 32'(bus.rsp_valid), 32'd0);
    chk("basic_ready_t5", 32'(bus.req_ready), 32'd1);
    chk("basic_err",      32'(bus.err_spurious), 32'd0);

    // ---------------- backpressure ----------------
    bus.req_valid = 1'b1;
    bus.req_data  = 32'h12345678;
    step();                                     // t+1 ISSUE
    bus.req_valid = 1'b0;
    step();                                     // t+2 WAIT
    bus.mc_done = 1'b1;
    bus.mc_out  = 32'hA5A5A5A5;
    step();                                     // t+3 RESP
    bus.mc_done = 1'b0;
    bus.mc_out  = 32'h0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_data",  bus.rsp_data, 32'hA5A5A5A5);
      chk("bp_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_inp",   bus.mc_inp, 32'h12345678);
      step();
    end
    chk("bp_valid_hold", 32'(bus.rsp_valid), 32'd1);
    bus.rsp_ready = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      chk("bp_one_rsp", 32'(bus.rsp_valid), 32'd0);
      step();
    end
    bus.rsp_ready = 1'b0;
    chk("bp_err", 32'(bus.err_spurious), 32'd0);

    // ---------------- boundary: done on the expiry cycle ----------------
    bus.req_valid = 1'b1;
    bus.req_data  = 32'h00C0FFEE;
    step();                                     // t+1
    bus.req_valid = 1'b0;
    step(); step(); step();                     // t+4
    chk("bnd_valid_t4", 32'(bus.rsp_valid), 32'd0);
    step();                                     // t+5: counter at TIMEOUT-1
    bus.mc_done = 1'b1;
    bus.mc_out  = 32'h0BADF00D;
    step();                                     // t+6
    bus.mc_done = 1'b0;
    bus.mc_out  = 32'h0;
    chk("bnd_valid", 32'(bus.rsp_valid), 32'd1);
    chk("bnd_data",  bus.rsp_data, 32'h0BADF00D);
    chk("bnd_tmo",   32'(bus.rsp_timeout), 32'd0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("bnd_err", 32'(bus.err_spurious), 32'd0);

    // ---------------- timeout + late done ----------------
    bus.req_valid = 1'b1;
    bus.req_data  = 32'h77777777;
    step();                                     // t+1
    bus.req_valid = 1'b0;
    for (int i = 0; i < TB_TIMEOUT; i++) begin
      chk("tmo_no_valid", 32'(bus.rsp_valid), 32'd0);
      step();                                   // ends at t+5
    end
    chk("tmo_no_valid_t5", 32'(bus.rsp_valid), 32'd0);
    step();                                     // t+6
    chk("tmo_valid", 32'(bus.rsp_valid), 32'd1);
    chk("tmo_data",  bus.rsp_data, 32'd0);
    chk("tmo_flag",  32'(bus.rsp_timeout), 32'd1);
    chk("tmo_err0",  32'(bus.err_spurious), 32'd0);
    bus.mc_done = 1'b1;                         // late done while in RESP
    bus.mc_out  = 32'hFFFF0000;
    step();                                     // t+7
    bus.mc_done = 1'b0;
    bus.mc_out  = 32'h0;
    chk("late_err",   32'(bus.err_spurious), 32'd1);
    chk("late_valid", 32'(bus.rsp_valid), 32'd1);
    chk("late_data",  bus.rsp_data, 32'd0);
    chk("late_tmo",   32'(bus.rsp_timeout), 32'd1);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("late_idle", 32'(bus.req_ready), 32'd1);

    // ---------------- reset mid-WAIT ----------------
    bus.req_valid = 1'b1;
    bus.req_data  = 32'h55AA55AA;
    step();                                     // t+1
    bus.req_valid = 1'b0;
    step(); step();                             // t+3
    chk("mrst_state", 32'(dut.state), 32'(WAIT));
    reset_n = 1'b0;
    #1;
    chk("mrst_mc_inp",    bus.mc_inp, 32'd0);
    chk("mrst_mc_start",  32'(bus.mc_start), 32'd0);
    chk("mrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mrst_rsp_tmo",   32'(bus.rsp_timeout), 32'd0);
    chk("mrst_err",       32'(bus.err_spurious), 32'd0);
    chk("mrst_rsp_data",  bus.rsp_data, 32'd0);
    step(); step();
    reset_n = 1'b1;
    step();
    chk("mrst_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_data  = 32'h11112222;
    step();                                     // t+1
    bus.req_valid = 1'b0;
    chk("post_start", 32'(bus.mc_start), 32'd1);
    chk("post_inp",   bus.mc_inp, 32'h11112222);
    step();                                     // t+2
    bus.mc_done = 1'b1;
    bus.mc_out  = 32'h33334444;
    step();                                     // t+3
    bus.mc_done = 1'b0;
    bus.mc_out  = 32'h0;
    chk("post_valid", 32'(bus.rsp_valid), 32'd1);
    chk("post_data",  bus.rsp_data, 32'h33334444);
    chk("post_tmo",   32'(bus.rsp_timeout), 32'd0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("post_idle", 32'(bus.req_ready), 32'd1);
    chk("post_err",  32'(bus.err_spurious), 32'd0);

    // ---------------- spurious done in IDLE ----------------
    bus.mc_done = 1'b1;
    bus.mc_out  = 32'hCAFEBABE;
    step();
    bus.mc_done = 1'b0;
    bus.mc_out  = 32'h0;
    chk("spur_err",   32'(bus.err_spurious), 32'd1);
    chk("spur_valid", 32'(bus.rsp_valid), 32'd0);
    chk("spur_ready", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("spur_sticky",   32'(bus.err_spurious), 32'd1);
      chk("spur_no_rsp",   32'(bus.rsp_valid), 32'd0);
      chk("spur_no_start", 32'(bus.mc_start), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
